// File: rtl/i2c_reg_bank_pkg.sv
// Shared definitions for the I2C register bank: frame states, default geometry, slave address.
package i2c_reg_bank_pkg;

   localparam int DEF_NREGS = 16;
   localparam int DEF_AW    = 4;

   // 7-bit device address, kept here so the slave port and the bank agree
   localparam logic [6:0] SLAVE_ADDR = 7'h2C;

   typedef enum logic [1:0] {
      S_PTR  = 2'd0,
      S_WR   = 2'd1,
      S_DROP = 2'd2
   } state_t;

endpackage

// File: rtl/i2c_reg_rdmux.sv
// Registered read mux: selects STATUS or register contents at PTR onto Q.
// One cycle from PTR/register change to Q; free-running, no backpressure.
module i2c_reg_rdmux
   import i2c_reg_bank_pkg::*;
#(
   parameter int               NREGS   = DEF_NREGS,
   parameter int               AW      = DEF_AW,
   parameter logic [NREGS-1:0] RO_MASK = '0
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NREGS*8-1:0] REG_OUT,
   input  logic [NREGS*8-1:0] STATUS,
   input  logic [AW-1:0]      PTR,
   output logic [7:0]         Q
);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         Q <= '0;
      end else if (RO_MASK[PTR]) begin
         Q <= STATUS[{PTR, 3'b000} +: 8];
      end else begin
         Q <= REG_OUT[{PTR, 3'b000} +: 8];
      end
   end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave: pointer-byte FSM, auto-increment writes/reads, flat export.
// Writes land one cycle after D_ready, Q follows PTR one cycle later; strobes are never stalled.
module i2c_reg_bank
   import i2c_reg_bank_pkg::*;
#(
   parameter int               NREGS   = DEF_NREGS,
   parameter int               AW      = DEF_AW,
   parameter logic [NREGS-1:0] RO_MASK = '0
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               ENB,
   input  logic [7:0]         D,
   input  logic               D_ready,
   input  logic               FRAME_START,
   input  logic               RD_DONE,
   input  logic [NREGS*8-1:0] STATUS,
   output logic [7:0]         Q,
   output logic [NREGS*8-1:0] REG_OUT,
   output logic [NREGS-1:0]   WR_STROBE,
   output logic [AW-1:0]      PTR,
   output logic               ERR
);

   state_t             state;
   logic [NREGS*8-1:0] regs;
   logic [AW-1:0]      ptr;
   logic [AW-1:0]      ptr_nxt;
   logic [NREGS-1:0]   wr_strobe;
   logic               err;

   // wrap at NREGS, which may be smaller than 2**AW
   assign ptr_nxt = (ptr == AW'(NREGS - 1)) ? '0 : ptr + 1'b1;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_PTR;
         regs      <= '0;
         ptr       <= '0;
         wr_strobe <= '0;
         err       <= 1'b0;
      end else begin
         wr_strobe <= '0;
         if (ENB) begin
            if (FRAME_START) begin
               state <= S_PTR;
            end else if (D_ready) begin
               case (state)
                  S_PTR: begin
                     if ({24'h0, D} < NREGS) begin
                        ptr   <= D[AW-1:0];
                        state <= S_WR;
                     end else begin
                        err   <= 1'b1;
                        state <= S_DROP;
                     end
                  end
                  S_WR: begin
                     if (!RO_MASK[ptr]) begin
                        regs[{ptr, 3'b000} +: 8] <= D;
                        wr_strobe[ptr]           <= 1'b1;
                     end
                     ptr <= ptr_nxt;
                  end
                  default: begin
                  end
               endcase
            end else if (RD_DONE) begin
               ptr <= ptr_nxt;
            end
         end
      end
   end

   i2c_reg_rdmux #(
      .NREGS   (NREGS),
      .AW      (AW),
      .RO_MASK (RO_MASK)
   ) u_rdmux (
      .CLK     (CLK),
      .RESET   (RESET),
      .REG_OUT (regs),
      .STATUS  (STATUS),
      .PTR     (ptr),
      .Q       (Q)
   );

   assign REG_OUT   = regs;
   assign WR_STROBE = wr_strobe;
   assign PTR       = ptr;
   assign ERR       = err;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: directed frame scenarios plus random strobes against a byte-level model.
// Two instances share stimulus; the second has register 0 read-only.
module tb_i2c_reg_bank;

   localparam int N = 16;
   localparam logic [N-1:0] RO_MASK1 = 16'h0001;

   logic           CLK = 1'b0;
   logic           RESET, ENB, D_ready, FRAME_START, RD_DONE;
   logic [7:0]     D;
   logic [N*8-1:0] STATUS;
   logic [7:0]     q0, q1;
   logic [N*8-1:0] ro0, ro1;
   logic [N-1:0]   ws0, ws1;
   logic [3:0]     p0, p1;
   logic           e0, e1;

   int tests_run = 0;
   int tests_failed = 0;

   // model: registers per instance, pointer, sticky error, frame mode (0 pointer, 1 data, 2 drop)
   logic [7:0] m_regs [2][N];
   logic [N-1:0] m_strobe [2];
   logic [7:0] m_q [2];
   int m_ptr = 0;
   bit m_err = 1'b0;
   int m_mode = 0;

   always #5 CLK = ~CLK;

   i2c_reg_bank #(.NREGS(N), .AW(4), .RO_MASK(16'h0000)) dut (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .D(D), .D_ready(D_ready),
      .FRAME_START(FRAME_START), .RD_DONE(RD_DONE), .STATUS(STATUS),
      .Q(q0), .REG_OUT(ro0), .WR_STROBE(ws0), .PTR(p0), .ERR(e0));

   i2c_reg_bank #(.NREGS(N), .AW(4), .RO_MASK(RO_MASK1)) dut_ro (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .D(D), .D_ready(D_ready),
      .FRAME_START(FRAME_START), .RD_DONE(RD_DONE), .STATUS(STATUS),
      .Q(q1), .REG_OUT(ro1), .WR_STROBE(ws1), .PTR(p1), .ERR(e1));

   function automatic bit is_ro(input int k, input int p);
      return (k == 1) && RO_MASK1[p];
   endfunction

   function automatic logic [N*8-1:0] exp_bus(input int k);
      logic [N*8-1:0] b;
      for (int i = 0; i < N; i++) b[8*i +: 8] = m_regs[k][i];
      return b;
   endfunction

   task automatic model_step(input bit rst, input bit en, input bit fs, input bit dr,
                             input bit rd, input logic [7:0] d);
      m_strobe[0] = '0;
      m_strobe[1] = '0;
      if (rst) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) m_regs[k][i] = 8'h00;
         m_ptr = 0; m_err = 1'b0; m_mode = 0;
      end else if (en) begin
         if (fs) begin
            m_mode = 0;
         end else if (dr) begin
            if (m_mode == 0) begin
               if (int'(d) < N) begin m_ptr = int'(d); m_mode = 1; end
               else begin m_err = 1'b1; m_mode = 2; end
            end else if (m_mode == 1) begin
               for (int k = 0; k < 2; k++)
                  if (!is_ro(k, m_ptr)) begin
                     m_regs[k][m_ptr] = d;
                     m_strobe[k][m_ptr] = 1'b1;
                  end
               m_ptr = (m_ptr + 1) % N;
            end
         end else if (rd) begin
            m_ptr = (m_ptr + 1) % N;
         end
      end
   endtask

   // one clock: drive, advance model, sample #1 after the edge, release strobes
   task automatic cycle(input bit rst, input bit en, input bit fs, input bit dr,
                        input bit rd, input logic [7:0] d);
      RESET = rst; ENB = en; FRAME_START = fs; D_ready = dr; RD_DONE = rd; D = d;
      for (int k = 0; k < 2; k++)
         m_q[k] = rst ? 8'h00 : (is_ro(k, m_ptr) ? STATUS[8*m_ptr +: 8] : m_regs[k][m_ptr]);
      model_step(rst, en, fs, dr, rd, d);
      @(posedge CLK);
      #1;
      RESET = 1'b0; ENB = 1'b1; FRAME_START = 1'b0; D_ready = 1'b0; RD_DONE = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      cycle(0, 1, 0, 1, 0, d);
   endtask

   task automatic test_reset();
      cycle(1, 1, 0, 0, 0, 8'h00);
      tests_run++; if (ro0 !== '0) begin tests_failed++; $display("FAIL reset_regs: got %h want 0", ro0); end
      tests_run++; if (p0 !== 4'd0) begin tests_failed++; $display("FAIL reset_ptr: got %0d want 0", p0); end
      tests_run++; if (e0 !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", e0); end
      tests_run++; if (ws0 !== '0) begin tests_failed++; $display("FAIL reset_strobe: got %h want 0", ws0); end
      tests_run++; if (q0 !== 8'h00 || q1 !== 8'h00) begin tests_failed++; $display("FAIL reset_q: got %h/%h want 00", q0, q1); end
   endtask

   task automatic test_write();
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h03); wr(8'hA5);
      tests_run++; if (ws0 !== 16'h0008) begin tests_failed++; $display("FAIL write_strobe3: got %h want 0008", ws0); end
      tests_run++; if (ro0[31:24] !== 8'hA5) begin tests_failed++; $display("FAIL write_reg3: got %h want a5", ro0[31:24]); end
      wr(8'h5A);
      tests_run++; if (ws0 !== 16'h0010) begin tests_failed++; $display("FAIL write_strobe4: got %h want 0010", ws0); end
      tests_run++; if (ro0[39:32] !== 8'h5A) begin tests_failed++; $display("FAIL write_reg4: got %h want 5a", ro0[39:32]); end
      cycle(0, 1, 0, 0, 0, 8'h00);
      tests_run++; if (ws0 !== '0) begin tests_failed++; $display("FAIL write_strobe_idle: got %h want 0", ws0); end
      tests_run++; if (p0 !== 4'd5) begin tests_failed++; $display("FAIL write_ptr: got %0d want 5", p0); end
   endtask

   task automatic test_wrap();
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h0F); wr(8'h11);
      tests_run++; if (ro0[127:120] !== 8'h11) begin tests_failed++; $display("FAIL wrap_reg15: got %h want 11", ro0[127:120]); end
      wr(8'h22);
      tests_run++; if (ro0[7:0] !== 8'h22 || ws0 !== 16'h0001) begin tests_failed++; $display("FAIL wrap_reg0: got %h/%h want 22/0001", ro0[7:0], ws0); end
      tests_run++; if (ro1[7:0] !== 8'h00 || ws1 !== '0) begin tests_failed++; $display("FAIL wrap_ro_reg0: got %h/%h want 00/0000", ro1[7:0], ws1); end
      tests_run++; if (p0 !== 4'd1) begin tests_failed++; $display("FAIL wrap_ptr: got %0d want 1", p0); end
   endtask

   task automatic test_read();
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h02); wr(8'h21); wr(8'h32); wr(8'h43);
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h02);
      cycle(0, 1, 1, 0, 0, 8'h00); cycle(0, 1, 0, 0, 0, 8'h00);
      tests_run++; if (q0 !== 8'h21) begin tests_failed++; $display("FAIL read_q0: got %h want 21", q0); end
      cycle(0, 1, 0, 0, 1, 8'h00); cycle(0, 1, 0, 0, 0, 8'h00);
      tests_run++; if (q0 !== 8'h32) begin tests_failed++; $display("FAIL read_q1: got %h want 32", q0); end
      cycle(0, 1, 0, 0, 1, 8'h00); cycle(0, 1, 0, 0, 0, 8'h00);
      tests_run++; if (q0 !== 8'h43) begin tests_failed++; $display("FAIL read_q2: got %h want 43", q0); end
      cycle(0, 1, 0, 0, 1, 8'h00);
      tests_run++; if (p0 !== 4'd5) begin tests_failed++; $display("FAIL read_ptr: got %0d want 5", p0); end
      tests_run++; if (ws0 !== '0) begin tests_failed++; $display("FAIL read_strobe: got %h want 0", ws0); end
   endtask

   task automatic test_bad_ptr();
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h20);
      tests_run++; if (e0 !== 1'b1 || p0 !== 4'd5) begin tests_failed++; $display("FAIL badptr_err: got err %b ptr %0d want 1/5", e0, p0); end
      wr(8'h77);
      tests_run++; if (ws0 !== '0 || ro0 !== exp_bus(0)) begin tests_failed++; $display("FAIL badptr_drop: got strobe %h regs %h", ws0, ro0); end
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h06); wr(8'h99);
      tests_run++; if (ro0[55:48] !== 8'h99 || ws0 !== 16'h0040) begin tests_failed++; $display("FAIL badptr_recover: got %h/%h want 99/0040", ro0[55:48], ws0); end
      tests_run++; if (e0 !== 1'b1) begin tests_failed++; $display("FAIL badptr_sticky: got %b want 1", e0); end
   endtask

   task automatic test_ro();
      STATUS = {$urandom, $urandom, $urandom, $urandom};
      STATUS[7:0] = 8'hC3;
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h00); wr(8'hFF);
      tests_run++; if (ws1 !== '0 || ro1[7:0] !== 8'h00) begin tests_failed++; $display("FAIL ro_nowrite: got %h/%h want 0000/00", ws1, ro1[7:0]); end
      tests_run++; if (p1 !== 4'd1) begin tests_failed++; $display("FAIL ro_ptr: got %0d want 1", p1); end
      tests_run++; if (ro0[7:0] !== 8'hFF || ws0 !== 16'h0001) begin tests_failed++; $display("FAIL rw_write: got %h/%h want ff/0001", ro0[7:0], ws0); end
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h00); cycle(0, 1, 1, 0, 0, 8'h00); cycle(0, 1, 0, 0, 0, 8'h00);
      tests_run++; if (q1 !== 8'hC3 || q0 !== 8'hFF) begin tests_failed++; $display("FAIL ro_read: got %h/%h want c3/ff", q1, q0); end
   endtask

   task automatic test_priority();
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h03);
      cycle(0, 1, 1, 1, 0, 8'hEE);
      tests_run++; if (ws0 !== '0 || ro0 !== exp_bus(0)) begin tests_failed++; $display("FAIL prio_fs_drop: got strobe %h regs %h", ws0, ro0); end
      wr(8'h07);
      tests_run++; if (p0 !== 4'd7 || ws0 !== '0) begin tests_failed++; $display("FAIL prio_ptr_state: got %0d/%h want 7/0000", p0, ws0); end
      cycle(0, 0, 1, 1, 1, 8'h55);
      tests_run++; if (p0 !== 4'd7 || ws0 !== '0 || ro0 !== exp_bus(0)) begin tests_failed++; $display("FAIL enb_hold: got ptr %0d strobe %h", p0, ws0); end
      cycle(0, 1, 0, 1, 1, 8'h3C);
      tests_run++; if (ws0 !== 16'h0080 || p0 !== 4'd8) begin tests_failed++; $display("FAIL prio_rd_drop: got %h/%0d want 0080/8", ws0, p0); end
   endtask

   task automatic test_reset_mid();
      cycle(0, 1, 1, 0, 0, 8'h00); wr(8'h04); wr(8'hAB);
      cycle(1, 1, 1, 1, 1, 8'h12);
      tests_run++; if (ro0 !== '0 || ro1 !== '0) begin tests_failed++; $display("FAIL rstmid_regs: got %h", ro0); end
      tests_run++; if (p0 !== 4'd0 || e0 !== 1'b0 || ws0 !== '0 || q0 !== 8'h00) begin tests_failed++; $display("FAIL rstmid_outs: got ptr %0d err %b strobe %h q %h", p0, e0, ws0, q0); end
      wr(8'h09);
      tests_run++; if (p0 !== 4'd9 || ws0 !== '0) begin tests_failed++; $display("FAIL rstmid_state: got %0d/%h want 9/0000", p0, ws0); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bit rst, en, fs, dr, rd;
         logic [7:0] d;
         if ($urandom_range(0, 19) == 0) STATUS = {$urandom, $urandom, $urandom, $urandom};
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 9) != 0);
         fs  = ($urandom_range(0, 7) == 0);
         dr  = ($urandom_range(0, 2) == 0);
         rd  = ($urandom_range(0, 3) == 0);
         d   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, N - 1));
         cycle(rst, en, fs, dr, rd, d);
         tests_run++; if (ro0 !== exp_bus(0)) begin tests_failed++; $display("FAIL rand_regs0 cyc %0d: got %h want %h", c, ro0, exp_bus(0)); end
         tests_run++; if (ro1 !== exp_bus(1)) begin tests_failed++; $display("FAIL rand_regs1 cyc %0d: got %h want %h", c, ro1, exp_bus(1)); end
         tests_run++; if (ws0 !== m_strobe[0]) begin tests_failed++; $display("FAIL rand_strobe0 cyc %0d: got %h want %h", c, ws0, m_strobe[0]); end
         tests_run++; if (ws1 !== m_strobe[1]) begin tests_failed++; $display("FAIL rand_strobe1 cyc %0d: got %h want %h", c, ws1, m_strobe[1]); end
         tests_run++; if (p0 !== 4'(m_ptr) || p1 !== 4'(m_ptr)) begin tests_failed++; $display("FAIL rand_ptr cyc %0d: got %0d/%0d want %0d", c, p0, p1, m_ptr); end
         tests_run++; if (e0 !== m_err || e1 !== m_err) begin tests_failed++; $display("FAIL rand_err cyc %0d: got %b/%b want %b", c, e0, e1, m_err); end
         tests_run++; if (q0 !== m_q[0]) begin tests_failed++; $display("FAIL rand_q0 cyc %0d: got %h want %h", c, q0, m_q[0]); end
         tests_run++; if (q1 !== m_q[1]) begin tests_failed++; $display("FAIL rand_q1 cyc %0d: got %h want %h", c, q1, m_q[1]); end
      end
   endtask

   initial begin
      RESET = 1'b1; ENB = 1'b1; D_ready = 1'b0; FRAME_START = 1'b0; RD_DONE = 1'b0;
      D = 8'h00; STATUS = '0;
      test_reset();
      test_write();
      test_wrap();
      test_read();
      test_bad_ptr();
      test_ro();
      test_priority();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
